// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential signed divider.
package seq_divider_pkg;

  localparam int DW = 16;  // dividend width
  localparam int VW = 8;   // divisor / quotient / remainder width

  typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} div_state_t;

  // One count value per dividend bit (DW = 16 -> 4 bits).
  typedef logic [3:0] count_t;

  localparam count_t        COUNT_LOAD   = 4'd15;
  localparam logic [VW-1:0] DBZ_QUOTIENT = 8'hFF;
  localparam logic [VW-1:0] Q_MAX        = 8'h7F;  // +127
  localparam logic [VW-1:0] Q_MIN        = 8'h80;  // -128

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for seq_divider.
// Values are carried as raw bit vectors; the divider interprets them as
// two's complement.
interface seq_divider_if;
  import seq_divider_pkg::*;

  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic [VW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          done;
  logic          busy;
  logic          dbz;
  logic          ovf;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, done, busy, dbz, ovf
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, done, busy, dbz, ovf
  );

endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift the next dividend bit into the
// partial remainder and trial-subtract the divisor magnitude.
module div_step
  import seq_divider_pkg::*;
(
  input  logic [VW:0]   prem,       // partial remainder, always < dvsr
  input  logic          next_bit,   // next dividend bit, MSB first
  input  logic [VW-1:0] dvsr,       // |divisor|, 1..128
  output logic [VW:0]   prem_next,
  output logic          q_bit
);

  logic [VW+1:0] shifted;
  logic [VW+1:0] trial;

  // Shift, trial subtract, keep the difference only when it is non-negative.
  always_comb begin
    shifted   = {prem, next_bit};
    trial     = shifted - {2'b00, dvsr};
    q_bit     = ~trial[VW+1];
    prem_next = q_bit ? trial[VW:0] : shifted[VW:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential signed divider: 16-bit dividend / 8-bit divisor -> 8-bit
// quotient (truncated toward zero) and 8-bit remainder (sign of dividend).
// Sign-magnitude restoring division, one quotient bit per clock.
// Build option: define OVF_CHECK_EN to flag and saturate quotients outside
// [-128,127]; otherwise the quotient is the low 8 bits and ovf stays 0.
module seq_divider
  import seq_divider_pkg::*;
(
  input  logic         clk,
  input  logic         reset,   // asynchronous, active-low
  seq_divider_if.slave bus
);

  div_state_t    state_q, state_d;
  count_t        count_q;
  logic [DW-1:0] dd_q;          // |dividend|, shifted out MSB-first; fills with quotient bits
  logic [VW-1:0] dv_q;          // |divisor|
  logic [VW:0]   prem_q;        // partial remainder
  logic          neg_quo_q;     // operand signs differ
  logic          neg_rem_q;     // dividend negative

  logic [VW-1:0] quotient_q, remainder_q;
  logic          dbz_q, ovf_q;

  logic          accept, div_zero;
  logic [DW-1:0] dd_mag;
  logic [VW-1:0] dv_mag;
  logic [VW:0]   prem_step;
  logic          q_bit;
  logic [VW-1:0] quo_fix, rem_fix;
  logic          ovf_fix;

  assign accept   = bus.start && ((state_q == IDLE) || (state_q == DONE));
  assign div_zero = (bus.divisor == '0);

  // 16 unsigned bits hold |-32768| = 32768, so the most negative dividend is safe.
  assign dd_mag = bus.dividend[DW-1] ? (~bus.dividend + 1'b1) : bus.dividend;
  assign dv_mag = bus.divisor[VW-1]  ? (~bus.divisor + 1'b1)  : bus.divisor;

  div_step u_step (
    .prem      (prem_q),
    .next_bit  (dd_q[DW-1]),
    .dvsr      (dv_q),
    .prem_next (prem_step),
    .q_bit     (q_bit)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (accept) state_d = div_zero ? DONE : DIV;
      DIV:        if (count_q == '0) state_d = FIX;
      FIX:        state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Sign fix-up of the magnitude results, with optional overflow saturation.
  always_comb begin
    rem_fix = neg_rem_q ? (~prem_q[VW-1:0] + 1'b1) : prem_q[VW-1:0];
    quo_fix = neg_quo_q ? (~dd_q[VW-1:0] + 1'b1) : dd_q[VW-1:0];
    ovf_fix = 1'b0;
`ifdef OVF_CHECK_EN
    if (!neg_quo_q && (dd_q > DW'(127))) begin
      quo_fix = Q_MAX;
      ovf_fix = 1'b1;
    end else if (neg_quo_q && (dd_q > DW'(128))) begin
      quo_fix = Q_MIN;
      ovf_fix = 1'b1;
    end
`endif
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: every datapath register is reset so an abandoned run never
    // exposes a partial result; there is no memory array here to exempt.
    if (!reset) begin
      count_q     <= '0;
      dd_q        <= '0;
      dv_q        <= '0;
      prem_q      <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            if (div_zero) begin
              quotient_q  <= DBZ_QUOTIENT;
              remainder_q <= bus.dividend[VW-1:0];
              dbz_q       <= 1'b1;
              ovf_q       <= 1'b0;
            end else begin
              dd_q      <= dd_mag;
              dv_q      <= dv_mag;
              prem_q    <= '0;
              neg_quo_q <= bus.dividend[DW-1] ^ bus.divisor[VW-1];
              neg_rem_q <= bus.dividend[DW-1];
              count_q   <= COUNT_LOAD;
              dbz_q     <= 1'b0;
              ovf_q     <= 1'b0;
            end
          end
        end
        DIV: begin
          prem_q  <= prem_step;
          dd_q    <= {dd_q[DW-2:0], q_bit};
          count_q <= count_q - 1'b1;
        end
        FIX: begin
          quotient_q  <= quo_fix;
          remainder_q <= rem_fix;
          ovf_q       <= ovf_fix;
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.dbz       = dbz_q;
  assign bus.ovf       = ovf_q;
  assign bus.done      = (state_q == DONE);
  assign bus.busy      = (state_q == DIV) || (state_q == FIX);

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider.
// Expected values are hand-computed; overflow cases follow OVF_CHECK_EN.
module tb_seq_divider;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  seq_divider_if bus ();

  seq_divider dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // Pulse start for one cycle, wait for done (bounded), check result and latency.
  // Latency counts clock edges from the edge that samples start to done visible.
  // glitch_at > 0 raises start again with other operands mid-run.
  task automatic run(input string tag, input int dvd, input int dvs,
                     input logic [7:0] exp_q, input logic [7:0] exp_r,
                     input logic exp_dbz, input logic exp_ovf,
                     input int exp_lat, input int glitch_at);
    int   cycles;
    logic busy_seen;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 16'(dvd);
    bus.divisor  = 8'(dvs);
    cycles       = 0;
    busy_seen    = 1'b0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
      busy_seen = busy_seen | bus.busy;
      if (cycles == glitch_at) begin
        bus.start    = 1'b1;
        bus.dividend = 16'd77;
        bus.divisor  = 8'd7;
      end else begin
        bus.start = 1'b0;
      end
    end while (!bus.done && cycles < 40);
    check({tag, "_lat"}, 32'(cycles),        32'(exp_lat));
    check({tag, "_q"},   32'(bus.quotient),  32'(exp_q));
    check({tag, "_r"},   32'(bus.remainder), 32'(exp_r));
    check({tag, "_dbz"}, 32'(bus.dbz),       32'(exp_dbz));
    check({tag, "_ovf"}, 32'(bus.ovf),       32'(exp_ovf));
    if (exp_dbz) check({tag, "_busy"}, 32'(busy_seen), 32'(0));
  endtask

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_q",    32'(bus.quotient),  32'(0));
    check("rst_r",    32'(bus.remainder), 32'(0));
    check("rst_done", 32'(bus.done),      32'(0));
    check("rst_busy", 32'(bus.busy),      32'(0));
    check("rst_dbz",  32'(bus.dbz),       32'(0));
    check("rst_ovf",  32'(bus.ovf),       32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Basic and sign combinations.
    run("p30_6",   30,  6,  8'h05, 8'h00, 1'b0, 1'b0, 18, 0);
    run("n35_7",  -35,  7,  8'hFB, 8'h00, 1'b0, 1'b0, 18, 0);
    run("p37_n5",  37, -5,  8'hF9, 8'h02, 1'b0, 1'b0, 18, 0);
    run("n37_5",  -37,  5,  8'hF9, 8'hFE, 1'b0, 1'b0, 18, 0);
    run("n36_n9", -36, -9,  8'h04, 8'h00, 1'b0, 1'b0, 18, 0);
    // Divisor -128 and an exact product of extreme operands.
    run("p100_n128",  100,   -128, 8'h00, 8'h64, 1'b0, 1'b0, 18, 0);
    run("n16256_n128", -16256, -128, 8'h7F, 8'h00, 1'b0, 1'b0, 18, 0);
    run("n128_1",     -128,   1,   8'h80, 8'h00, 1'b0, 1'b0, 18, 0);

    // Quotients outside [-128,127].
`ifdef OVF_CHECK_EN
    run("p1000_7",    1000,   7, 8'h7F, 8'h06, 1'b0, 1'b1, 18, 0);
    run("n1000_7",   -1000,   7, 8'h80, 8'hFA, 1'b0, 1'b1, 18, 0);
    run("n32768_n1", -32768, -1, 8'h7F, 8'h00, 1'b0, 1'b1, 18, 0);
    run("n128_n1",    -128,  -1, 8'h7F, 8'h00, 1'b0, 1'b1, 18, 0);
`else
    run("p1000_7",    1000,   7, 8'h8E, 8'h06, 1'b0, 1'b0, 18, 0);
    run("n1000_7",   -1000,   7, 8'h72, 8'hFA, 1'b0, 1'b0, 18, 0);
    run("n32768_n1", -32768, -1, 8'h00, 8'h00, 1'b0, 1'b0, 18, 0);
    run("n128_n1",    -128,  -1, 8'h80, 8'h00, 1'b0, 1'b0, 18, 0);
`endif

    // Divide by zero: immediate done, busy never raised.
    run("p123_0", 123, 0, 8'hFF, 8'h7B, 1'b1, 1'b0, 1, 0);

    // Asynchronous reset in the middle of DIV.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 16'd1000;
    bus.divisor  = 8'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("mid_busy", 32'(bus.busy), 32'(1));
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_q",    32'(bus.quotient),  32'(0));
    check("arst_r",    32'(bus.remainder), 32'(0));
    check("arst_done", 32'(bus.done),      32'(0));
    check("arst_busy", 32'(bus.busy),      32'(0));
    check("arst_dbz",  32'(bus.dbz),       32'(0));
    check("arst_ovf",  32'(bus.ovf),       32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run("p99_9", 99, 9, 8'h0B, 8'h00, 1'b0, 1'b0, 18, 0);

    // start pulsed mid-DIV must be ignored.
    run("p50_5_glitch", 50, 5, 8'h0A, 8'h00, 1'b0, 1'b0, 18, 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1);
  end

endmodule
